// File: rtl/enable_period_checker_pkg.sv
// Package: enable_period_checker_pkg
// Purpose: shared state encoding and default parameter values for the
//          enable strobe period checker.
// Contents:
//   state_t        FSM state type (IDLE / MEASURE / LOCKED, code 3 unused)
//   DEF_EXPECTED   default required strobe period in clk cycles
//   DEF_WIDTH      default gap counter / period width
//   DEF_LOCK_CNT   default number of matching periods needed to lock
//   DEF_LOCK_W     default match counter width
package enable_period_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam int DEF_EXPECTED = 10;
    localparam int DEF_WIDTH    = 4;
    localparam int DEF_LOCK_CNT = 3;
    localparam int DEF_LOCK_W   = 2;

endpackage

// File: rtl/enable_period_checker_if.sv
// Interface: enable_period_checker_if
// Purpose: groups the strobe input, synchronous clear and all measurement
//          outputs of the period checker into one bundle.
// Signals:
//   i_sclr        synchronous clear toward the checker
//   i_en          strobe under test toward the checker
//   o_period      last measured period (WIDTH bits)
//   o_period_vld  one-cycle pulse, new o_period
//   o_locked      level, checker is locked
//   o_err         one-cycle pulse, period mismatch while locked
//   o_timeout     one-cycle pulse, strobes stopped
// Modports:
//   master        strobe source / observer side
//   slave         checker side
interface enable_period_checker_if
    import enable_period_checker_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             i_sclr;
    logic             i_en;
    logic [WIDTH-1:0] o_period;
    logic             o_period_vld;
    logic             o_locked;
    logic             o_err;
    logic             o_timeout;

    modport master (
        output i_sclr, i_en,
        input  o_period, o_period_vld, o_locked, o_err, o_timeout
    );

    modport slave (
        input  i_sclr, i_en,
        output o_period, o_period_vld, o_locked, o_err, o_timeout
    );

endinterface

// File: rtl/enable_period_checker_sat_counter.sv
// Module: enable_period_checker_sat_counter
// Purpose: gap counter for the period checker. Loads 1 on a strobe edge,
//          otherwise counts up and sticks at its all-ones value.
// Ports:
//   clk          in   rising-edge clock
//   i_rst_n      in   asynchronous active-low reset
//   i_sclr       in   synchronous clear, wins over i_load1
//   i_load1      in   strobe; counter restarts at 1
//   o_cnt        out  current gap count (WIDTH bits)
//   o_at_max_m1  out  count is one below saturation
module enable_period_checker_sat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_sclr,
    input  logic             i_load1,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_at_max_m1
);

    localparam logic [WIDTH-1:0] CNT_MAX    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_MAX_M1 = CNT_MAX - 1'b1;

    // The strobe edge itself counts as the first cycle of the new gap,
    // so a strobe restarts at 1 and the value seen at the next strobe is
    // the period directly.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cnt <= '0;
        end else if (i_sclr) begin
            o_cnt <= '0;
        end else if (i_load1) begin
            o_cnt <= {{(WIDTH-1){1'b0}}, 1'b1};
        end else if (o_cnt != CNT_MAX) begin
            o_cnt <= o_cnt + 1'b1;
        end
    end

    // Flags the edge on which the counter would reach saturation.
    assign o_at_max_m1 = (o_cnt == CNT_MAX_M1);

endmodule

// File: rtl/enable_period_checker.sv
// Module: enable_period_checker
// Purpose: receive-side monitor for a periodic one-cycle enable strobe.
//          Measures the clk edges between strobes, reports each period,
//          locks after LOCK_CNT consecutive periods equal to EXPECTED, and
//          flags lost lock and missing strobes.
// Parameters:
//   EXPECTED   required period (1 .. 2**WIDTH-2)
//   WIDTH      gap counter / o_period width
//   LOCK_CNT   matching periods needed to lock (1 .. 2**LOCK_W-1)
//   LOCK_W     match counter width
// Ports:
//   clk        in   rising-edge clock
//   i_rst_n    in   asynchronous active-low reset
//   bus        slave modport: i_sclr, i_en in; o_period, o_period_vld,
//              o_locked, o_err, o_timeout out
module enable_period_checker
    import enable_period_checker_pkg::*;
#(
    parameter int EXPECTED = DEF_EXPECTED,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LOCK_CNT = DEF_LOCK_CNT,
    parameter int LOCK_W   = DEF_LOCK_W
) (
    input  logic                   clk,
    input  logic                   i_rst_n,
    enable_period_checker_if.slave bus
);

    localparam logic [WIDTH-1:0]  EXP_V  = WIDTH'(EXPECTED);
    localparam logic [LOCK_W:0]   LOCK_V = (LOCK_W+1)'(LOCK_CNT);

    state_t              state_q, state_d;
    logic [LOCK_W-1:0]   match_q, match_d;
    logic [LOCK_W:0]     match_inc;
    logic [WIDTH-1:0]    period_q, period_d;
    logic                vld_q, vld_d;
    logic                err_q, err_d;
    logic                timeout_q, timeout_d;
    logic [WIDTH-1:0]    gap;
    logic                gap_at_max_m1;

    enable_period_checker_sat_counter #(
        .WIDTH (WIDTH)
    ) u_gap (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_sclr      (bus.i_sclr),
        .i_load1     (bus.i_en),
        .o_cnt       (gap),
        .o_at_max_m1 (gap_at_max_m1)
    );

    // One bit wider than the match counter so the lock comparison sees the
    // true incremented value even when the counter itself saturates.
    assign match_inc = {1'b0, match_q} + 1'b1;

    // Next-state and next-output logic. Pulses default low every cycle so
    // they only last the one edge that raised them.
    always_comb begin
        state_d   = state_q;
        match_d   = match_q;
        period_d  = period_q;
        vld_d     = 1'b0;
        err_d     = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_en) begin
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE, ST_LOCKED: begin
                if (bus.i_en) begin
                    period_d = gap;
                    vld_d    = 1'b1;
                    if (gap == EXP_V) begin
                        if (match_q != {LOCK_W{1'b1}}) begin
                            match_d = match_inc[LOCK_W-1:0];
                        end
                        if (match_inc == LOCK_V) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        match_d = '0;
                        if (state_q == ST_LOCKED) begin
                            err_d   = 1'b1;
                            state_d = ST_MEASURE;
                        end
                    end
                end else if (gap_at_max_m1) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                    match_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                match_d = '0;
            end
        endcase
    end

    // State and output registers; the synchronous clear wins over any
    // strobe arriving on the same edge.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            match_q   <= '0;
            period_q  <= '0;
            vld_q     <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else if (bus.i_sclr) begin
            state_q   <= ST_IDLE;
            match_q   <= '0;
            period_q  <= '0;
            vld_q     <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            match_q   <= match_d;
            period_q  <= period_d;
            vld_q     <= vld_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.o_period     = period_q;
    assign bus.o_period_vld = vld_q;
    assign bus.o_locked     = (state_q == ST_LOCKED);
    assign bus.o_err        = err_q;
    assign bus.o_timeout    = timeout_q;

endmodule

// File: tb/tb_enable_period_checker.sv
// Testbench: tb_enable_period_checker
// Purpose: drives two checker instances (LOCK_CNT=3 and LOCK_CNT=1) with the
//          same strobe stream. A table of hand-derived vectors covers the
//          steady, early-strobe, timeout, back-to-back and clear cases; a
//          mid-cycle reset sequence follows; then a randomized strobe stream
//          is compared every edge against a behavioural model of both.
module tb_enable_period_checker;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    enable_period_checker_if #(.WIDTH(4)) bus_a ();
    enable_period_checker_if #(.WIDTH(4)) bus_b ();

    enable_period_checker #(
        .EXPECTED (10), .WIDTH (4), .LOCK_CNT (3), .LOCK_W (2)
    ) dut_a (
        .clk     (clk),
        .i_rst_n (rst_n),
        .bus     (bus_a.slave)
    );

    enable_period_checker #(
        .EXPECTED (10), .WIDTH (4), .LOCK_CNT (1), .LOCK_W (2)
    ) dut_b (
        .clk     (clk),
        .i_rst_n (rst_n),
        .bus     (bus_b.slave)
    );

    // Behavioural model: time since the last strobe, whether a reference
    // strobe exists, and the run length of consecutive good periods.
    typedef struct {
        int         since;
        bit         armed;
        int         streak;
        logic [3:0] period;
        bit         vld;
        bit         locked;
        bit         err;
        bit         to;
    } model_t;

    typedef struct {
        int         pre;
        bit         en;
        bit         sclr;
        bit         vld;
        logic [3:0] per;
        bit         lock;
        bit         err;
        bit         to;
        bit         lock_b;
    } vec_t;

    model_t ma, mb;
    vec_t   tbl[$];
    int     checks = 0;
    int     passes = 0;

    function automatic model_t modelReset();
        model_t m;
        m.since  = 0;
        m.armed  = 1'b0;
        m.streak = 0;
        m.period = 4'd0;
        m.vld    = 1'b0;
        m.locked = 1'b0;
        m.err    = 1'b0;
        m.to     = 1'b0;
        return m;
    endfunction

    function automatic model_t modelStep(model_t m, bit en, bit sclr, int lock_cnt);
        model_t n;
        int     gap_before;
        if (sclr) return modelReset();
        n = m;
        n.vld = 1'b0;
        n.err = 1'b0;
        n.to  = 1'b0;
        gap_before = (m.since > 15) ? 15 : m.since;
        if (en) begin
            if (m.armed) begin
                n.period = 4'(gap_before);
                n.vld    = 1'b1;
                if (gap_before == 10) begin
                    n.streak = m.streak + 1;
                end else begin
                    n.err    = m.locked;
                    n.streak = 0;
                end
            end else begin
                n.armed = 1'b1;
            end
            n.since = 1;
        end else begin
            if (m.armed && gap_before == 14) begin
                n.to     = 1'b1;
                n.armed  = 1'b0;
                n.streak = 0;
            end
            n.since = (m.since > 100) ? 100 : m.since + 1;
        end
        n.locked = n.armed && (n.streak >= lock_cnt);
        return n;
    endfunction

    // Compares one instance's outputs against a required tuple.
    task automatic checkOutput(input string name,
                               input logic [3:0] act_per, input logic act_vld,
                               input logic act_lock, input logic act_err,
                               input logic act_to,
                               input logic [3:0] exp_per, input logic exp_vld,
                               input logic exp_lock, input logic exp_err,
                               input logic exp_to);
        checks++;
        if ({act_vld, act_per, act_lock, act_err, act_to} ===
            {exp_vld, exp_per, exp_lock, exp_err, exp_to}) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s at %0t: got vld=%b per=%0d lock=%b err=%b to=%b, expected vld=%b per=%0d lock=%b err=%b to=%b",
                     name, $time, act_vld, act_per, act_lock, act_err, act_to,
                     exp_vld, exp_per, exp_lock, exp_err, exp_to);
        end
    endtask

    task automatic checkModels(input string tag);
        checkOutput({tag, "_A"}, bus_a.o_period, bus_a.o_period_vld, bus_a.o_locked,
                    bus_a.o_err, bus_a.o_timeout,
                    ma.period, ma.vld, ma.locked, ma.err, ma.to);
        checkOutput({tag, "_B"}, bus_b.o_period, bus_b.o_period_vld, bus_b.o_locked,
                    bus_b.o_err, bus_b.o_timeout,
                    mb.period, mb.vld, mb.locked, mb.err, mb.to);
    endtask

    // Drives one clock edge's worth of inputs, then samples 1 time unit
    // after the edge and checks both instances against the model.
    task automatic applyStimulus(input bit en, input bit sclr);
        bus_a.i_en   = en;
        bus_a.i_sclr = sclr;
        bus_b.i_en   = en;
        bus_b.i_sclr = sclr;
        @(posedge clk);
        #1;
        ma = modelStep(ma, en, sclr, 3);
        mb = modelStep(mb, en, sclr, 1);
        checkModels("model");
    endtask

    initial begin
        int countdown;
        int target;
        bit en;
        bit sclr;

        // Steady lock, early strobe, saturation-edge strobe, timeout,
        // back-to-back strobes, and a clear coinciding with a locking strobe.
        tbl.push_back('{0, 1, 0, 0,  0, 0, 0, 0, 0});
        tbl.push_back('{9, 1, 0, 1, 10, 0, 0, 0, 1});
        tbl.push_back('{9, 1, 0, 1, 10, 0, 0, 0, 1});
        tbl.push_back('{9, 1, 0, 1, 10, 1, 0, 0, 1});
        tbl.push_back('{9, 1, 0, 1, 10, 1, 0, 0, 1});
        tbl.push_back('{6, 1, 0, 1,  7, 0, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 0,  7, 0, 0, 0, 0});
        tbl.push_back('{8, 1, 0, 1, 10, 0, 0, 0, 1});
        tbl.push_back('{9, 1, 0, 1, 10, 0, 0, 0, 1});
        tbl.push_back('{9, 1, 0, 1, 10, 1, 0, 0, 1});
        tbl.push_back('{13, 1, 0, 1, 14, 0, 1, 0, 0});
        tbl.push_back('{9, 1, 0, 1, 10, 0, 0, 0, 1});
        tbl.push_back('{9, 1, 0, 1, 10, 0, 0, 0, 1});
        tbl.push_back('{9, 1, 0, 1, 10, 1, 0, 0, 1});
        tbl.push_back('{13, 0, 0, 0, 10, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 0, 0, 10, 0, 0, 0, 0});
        tbl.push_back('{5, 1, 0, 0, 10, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0,  0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0,  0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 1,  1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 1,  1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0,  0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0,  0, 0, 0, 0, 0});
        tbl.push_back('{9, 1, 0, 1, 10, 0, 0, 0, 1});
        tbl.push_back('{9, 1, 0, 1, 10, 0, 0, 0, 1});
        tbl.push_back('{9, 1, 1, 0,  0, 0, 0, 0, 0});
        tbl.push_back('{9, 1, 0, 0,  0, 0, 0, 0, 0});

        // Reset state.
        rst_n        = 1'b0;
        bus_a.i_en   = 1'b0;
        bus_a.i_sclr = 1'b0;
        bus_b.i_en   = 1'b0;
        bus_b.i_sclr = 1'b0;
        ma = modelReset();
        mb = modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkModels("reset");
        rst_n = 1'b1;

        // Table-driven vectors.
        foreach (tbl[i]) begin
            repeat (tbl[i].pre) applyStimulus(1'b0, 1'b0);
            applyStimulus(tbl[i].en, tbl[i].sclr);
            checkOutput($sformatf("vec%0d_A", i), bus_a.o_period, bus_a.o_period_vld,
                        bus_a.o_locked, bus_a.o_err, bus_a.o_timeout,
                        tbl[i].per, tbl[i].vld, tbl[i].lock, tbl[i].err, tbl[i].to);
            checkOutput($sformatf("vec%0d_Block", i), 4'd0, 1'b0, bus_b.o_locked, 1'b0, 1'b0,
                        4'd0, 1'b0, tbl[i].lock_b, 1'b0, 1'b0);
        end

        // Lock, then pull reset low between edges: outputs clear at once.
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        repeat (3) begin
            repeat (9) applyStimulus(1'b0, 1'b0);
            applyStimulus(1'b1, 1'b0);
        end
        checkOutput("prelock_A", 4'd0, 1'b0, bus_a.o_locked, 1'b0, 1'b0,
                    4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        bus_a.i_en = 1'b0;
        bus_b.i_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        ma = modelReset();
        mb = modelReset();
        checkOutput("async_reset_A", bus_a.o_period, bus_a.o_period_vld, bus_a.o_locked,
                    bus_a.o_err, bus_a.o_timeout, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("async_reset_B", bus_b.o_period, bus_b.o_period_vld, bus_b.o_locked,
                    bus_b.o_err, bus_b.o_timeout, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0);

        // Randomized strobe stream, mostly on period 10 with occasional
        // short, long and missing gaps plus rare clears.
        countdown = 1;
        for (int n = 0; n < 3000; n++) begin
            countdown--;
            en = (countdown == 0);
            if (en) begin
                target = ($urandom_range(0, 9) < 7) ? 10 : int'($urandom_range(1, 18));
                countdown = target;
            end
            sclr = ($urandom_range(0, 299) == 0);
            applyStimulus(en, sclr);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
